// File: rtl/ic_bus_arbiter_pkg.sv
// Shared encodings for the ibus/dbus memory-port arbiter: FSM states,
// transaction owner and the starvation-counter width helper.
package ic_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IBUS = 1'b0,
    ARB_OWN_DBUS = 1'b1
  } arb_owner_e;

  // Bits needed to count 0..max_val inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ic_bus_prio_pick.sv
// Winner select between ibus and dbus (dbus first) plus the counter that
// forces an ibus win after STARVE_MAX consecutive contested dbus wins.
module ic_bus_prio_pick
  import ic_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ibus_req,
  input  logic dbus_req,
  input  logic arb_en,
  output logic req_any,
  output logic win_ibus
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          ibus_forced;

  always_comb begin
    ibus_forced  = ibus_req && dbus_req && (starve_cnt_q == STARVE_LIM);
    win_ibus     = ibus_req && (!dbus_req || ibus_forced);
    req_any      = ibus_req || dbus_req;
    starve_cnt_d = starve_cnt_q;
    // The count only moves when a transaction is actually taken.
    if (arb_en && req_any) begin
      if (win_ibus) begin
        starve_cnt_d = '0;
      end else if (ibus_req && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/ic_bus_arbiter.sv
// Shares a single memory port between ibus and dbus, one outstanding
// transaction at a time, with registered responses routed to the owner.
module ic_bus_arbiter
  import ic_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_ibus_req,
  input  logic              I_ibus_we,
  input  logic [ADDR_W-1:0] I_ibus_addr,
  input  logic [DATA_W-1:0] I_ibus_data,
  input  logic [MASK_W-1:0] I_ibus_mask,
  output logic [DATA_W-1:0] O_ibus_data,
  output logic              O_ibus_ready,
  input  logic              I_dbus_req,
  input  logic              I_dbus_we,
  input  logic [ADDR_W-1:0] I_dbus_addr,
  input  logic [DATA_W-1:0] I_dbus_data,
  input  logic [MASK_W-1:0] I_dbus_mask,
  output logic [DATA_W-1:0] O_dbus_data,
  output logic              O_dbus_ready,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_data,
  output logic [MASK_W-1:0] O_mem_mask,
  input  logic              I_mem_gnt,
  input  logic              I_mem_rvalid,
  input  logic [DATA_W-1:0] I_mem_data
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0] ibus_data_q, ibus_data_d;
  logic [DATA_W-1:0] dbus_data_q, dbus_data_d;
  logic              ibus_ready_q, ibus_ready_d;
  logic              dbus_ready_q, dbus_ready_d;

  logic              arb_en;
  logic              req_any;
  logic              win_ibus;
  logic              complete;

  assign arb_en = (state_q == ARB_IDLE);

  ic_bus_prio_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_pick (
    .clk      (clk),
    .rst      (rst),
    .ibus_req (I_ibus_req),
    .dbus_req (I_dbus_req),
    .arb_en   (arb_en),
    .req_any  (req_any),
    .win_ibus (win_ibus)
  );

  // rvalid may coincide with gnt, in which case ISSUE completes directly.
  assign complete = ((state_q == ARB_ISSUE) && I_mem_gnt && I_mem_rvalid) ||
                    ((state_q == ARB_WAIT) && I_mem_rvalid);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_mask_d   = mem_mask_q;
    ibus_data_d  = ibus_data_q;
    dbus_data_d  = dbus_data_q;
    ibus_ready_d = 1'b0;
    dbus_ready_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (req_any) begin
          state_d   = ARB_ISSUE;
          mem_req_d = 1'b1;
          if (win_ibus) begin
            owner_d    = ARB_OWN_IBUS;
            mem_we_d   = I_ibus_we;
            mem_addr_d = I_ibus_addr;
            mem_data_d = I_ibus_data;
            mem_mask_d = I_ibus_mask;
          end else begin
            owner_d    = ARB_OWN_DBUS;
            mem_we_d   = I_dbus_we;
            mem_addr_d = I_dbus_addr;
            mem_data_d = I_dbus_data;
            mem_mask_d = I_dbus_mask;
          end
        end
      end
      ARB_ISSUE: begin
        if (I_mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = I_mem_rvalid ? ARB_DONE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (I_mem_rvalid) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Writes still pulse ready but leave the requester's read data alone.
    if (complete) begin
      if (owner_q == ARB_OWN_IBUS) begin
        ibus_ready_d = 1'b1;
        if (!mem_we_q) begin
          ibus_data_d = I_mem_data;
        end
      end else begin
        dbus_ready_d = 1'b1;
        if (!mem_we_q) begin
          dbus_data_d = I_mem_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_OWN_DBUS;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_mask_q   <= '0;
      ibus_data_q  <= '0;
      dbus_data_q  <= '0;
      ibus_ready_q <= 1'b0;
      dbus_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_mask_q   <= mem_mask_d;
      ibus_data_q  <= ibus_data_d;
      dbus_data_q  <= dbus_data_d;
      ibus_ready_q <= ibus_ready_d;
      dbus_ready_q <= dbus_ready_d;
    end
  end

  assign O_mem_req    = mem_req_q;
  assign O_mem_we     = mem_we_q;
  assign O_mem_addr   = mem_addr_q;
  assign O_mem_data   = mem_data_q;
  assign O_mem_mask   = mem_mask_q;
  assign O_ibus_data  = ibus_data_q;
  assign O_ibus_ready = ibus_ready_q;
  assign O_dbus_data  = dbus_data_q;
  assign O_dbus_ready = dbus_ready_q;

endmodule

// File: tb/tb_ic_bus_arbiter.sv
// Directed bench for ic_bus_arbiter: a table of single transactions plus
// hand-written reset, starvation and reset-in-WAIT sequences.
module tb_ic_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req, ibus_we, dbus_req, dbus_we;
  logic [31:0] ibus_addr, ibus_wdata, dbus_addr, dbus_wdata;
  logic [3:0]  ibus_mask, dbus_mask;
  logic [31:0] ibus_rdata, dbus_rdata;
  logic        ibus_ready, dbus_ready;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ic_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .I_ibus_req   (ibus_req),
    .I_ibus_we    (ibus_we),
    .I_ibus_addr  (ibus_addr),
    .I_ibus_data  (ibus_wdata),
    .I_ibus_mask  (ibus_mask),
    .O_ibus_data  (ibus_rdata),
    .O_ibus_ready (ibus_ready),
    .I_dbus_req   (dbus_req),
    .I_dbus_we    (dbus_we),
    .I_dbus_addr  (dbus_addr),
    .I_dbus_data  (dbus_wdata),
    .I_dbus_mask  (dbus_mask),
    .O_dbus_data  (dbus_rdata),
    .O_dbus_ready (dbus_ready),
    .O_mem_req    (mem_req),
    .O_mem_we     (mem_we),
    .O_mem_addr   (mem_addr),
    .O_mem_data   (mem_wdata),
    .O_mem_mask   (mem_mask),
    .I_mem_gnt    (mem_gnt),
    .I_mem_rvalid (mem_rvalid),
    .I_mem_data   (mem_rdata)
  );

  typedef struct {
    logic        ireq, dreq, iwe, dwe;
    logic [31:0] iaddr, daddr, iwd, dwd;
    logic [3:0]  imask, dmask;
    int          gnt_dly;
    bit          same;
    logic [31:0] rdata;
    bit          exp_i;
    int          exp_cyc;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_mask;
    logic [31:0] exp_idata, exp_ddata;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plays the memory side of one transaction and returns what was seen.
  task automatic run_mem(input int gnt_dly, input bit same, input logic [31:0] rdata,
                         output bit got_i, output bit got_d, output int cycles,
                         output logic cw, output logic [31:0] ca, output logic [31:0] cd,
                         output logic [3:0] cm, output logic [31:0] rd_i,
                         output logic [31:0] rd_d, output bit stable);
    int phase = 0;
    int cnt = 0;
    got_i = 0; got_d = 0; cycles = 0; stable = 1;
    cw = 0; ca = 0; cd = 0; cm = 0; rd_i = 0; rd_d = 0;
    while (cycles < 40) begin
      tick();
      cycles++;
      mem_gnt = 0;
      mem_rvalid = 0;
      if (ibus_ready || dbus_ready) begin
        got_i = ibus_ready; got_d = dbus_ready;
        rd_i = ibus_rdata; rd_d = dbus_rdata;
        break;
      end
      if (phase == 0 && mem_req) begin
        cw = mem_we; ca = mem_addr; cd = mem_wdata; cm = mem_mask;
        phase = 1; cnt = 0;
        // Payload must already be latched: disturb the requester inputs.
        ibus_addr = ~ibus_addr; dbus_addr = ~dbus_addr;
        ibus_wdata = ~ibus_wdata; dbus_wdata = ~dbus_wdata;
        ibus_mask = ~ibus_mask; dbus_mask = ~dbus_mask;
      end
      if (phase == 1) begin
        if (!mem_req || mem_we !== cw || mem_addr !== ca || mem_wdata !== cd || mem_mask !== cm)
          stable = 0;
        if (cnt == gnt_dly) begin
          mem_gnt = 1;
          if (same) begin
            mem_rvalid = 1; mem_rdata = rdata; phase = 3;
          end else begin
            phase = 2;
          end
        end else begin
          cnt++;
        end
      end else if (phase == 2) begin
        if (mem_req) stable = 0;
        mem_rvalid = 1; mem_rdata = rdata; phase = 3;
      end
    end
  endtask

  bit          gi, gd, st;
  int          cyc;
  logic        cw;
  logic [31:0] ca, cd, rdi, rdd;
  logic [3:0]  cm;

  initial begin
    vecs[0] = '{1,0,0,0, 32'h8000_0000,32'h0,32'h0,32'h0, 4'hF,4'hF, 0,0, 32'h0000_0013,
                1,3, 0,32'h8000_0000,32'h0,4'hF, 32'h0000_0013,32'h0BAD_F00D};
    vecs[1] = '{0,1,0,0, 32'h0,32'h8000_0040,32'h0,32'h0, 4'hF,4'hF, 0,0, 32'h1234_5678,
                0,3, 0,32'h8000_0040,32'h0,4'hF, 32'h0000_0013,32'h1234_5678};
    vecs[2] = '{0,1,0,1, 32'h0,32'h8000_0100,32'h0,32'hDEAD_BEEF, 4'hF,4'b0011, 3,0, 32'hFFFF_FFFF,
                0,6, 1,32'h8000_0100,32'hDEAD_BEEF,4'b0011, 32'h0000_0013,32'h1234_5678};
    vecs[3] = '{1,1,0,0, 32'h8000_0004,32'h8000_0044,32'h0,32'h0, 4'hF,4'hF, 0,0, 32'hA5A5_0001,
                0,3, 0,32'h8000_0044,32'h0,4'hF, 32'h0000_0013,32'hA5A5_0001};
    vecs[4] = '{1,0,0,0, 32'h8000_0008,32'h0,32'h0,32'h0, 4'hF,4'hF, 0,1, 32'h0000_0093,
                1,2, 0,32'h8000_0008,32'h0,4'hF, 32'h0000_0093,32'hA5A5_0001};
    vecs[5] = '{1,1,1,1, 32'h8000_000C,32'h8000_0300,32'h1111_1111,32'hCAFE_0000, 4'hF,4'b1100, 1,1, 32'h0000_5555,
                0,3, 1,32'h8000_0300,32'hCAFE_0000,4'b1100, 32'h0000_0093,32'hA5A5_0001};
    vecs[6] = '{1,0,1,0, 32'h8000_0010,32'h0,32'h0000_00FF,32'h0, 4'b0001,4'hF, 2,0, 32'h0000_7777,
                1,5, 1,32'h8000_0010,32'h0000_00FF,4'b0001, 32'h0000_0093,32'hA5A5_0001};

    // Reset held with both requesters active.
    rst = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    ibus_req = 1; ibus_we = 0; ibus_addr = 32'h8000_0000; ibus_wdata = 0; ibus_mask = 4'hF;
    dbus_req = 1; dbus_we = 0; dbus_addr = 32'h8000_0200; dbus_wdata = 0; dbus_mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mem_req", mem_req, 0);
    end
    chk("rst_mem_payload", {mem_we, mem_mask, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ready", {ibus_ready, dbus_ready}, 0);
    chk("rst_rdata", {ibus_rdata, dbus_rdata}, 0);
    rst = 1;
    run_mem(0, 0, 32'h0BAD_F00D, gi, gd, cyc, cw, ca, cd, cm, rdi, rdd, st);
    chk("rst_first_winner", {gi, gd}, 2'b01);
    chk("rst_first_addr", ca, 32'h8000_0200);
    chk("rst_first_data", rdd, 32'h0BAD_F00D);
    ibus_req = 0; dbus_req = 0;
    tick();

    // Table of single transactions.
    for (int v = 0; v < 7; v++) begin
      ibus_req = vecs[v].ireq; ibus_we = vecs[v].iwe; ibus_addr = vecs[v].iaddr;
      ibus_wdata = vecs[v].iwd; ibus_mask = vecs[v].imask;
      dbus_req = vecs[v].dreq; dbus_we = vecs[v].dwe; dbus_addr = vecs[v].daddr;
      dbus_wdata = vecs[v].dwd; dbus_mask = vecs[v].dmask;
      run_mem(vecs[v].gnt_dly, vecs[v].same, vecs[v].rdata, gi, gd, cyc, cw, ca, cd, cm, rdi, rdd, st);
      chk($sformatf("v%0d_done", v), gi | gd, 1);
      chk($sformatf("v%0d_winner", v), {gi, gd}, {vecs[v].exp_i, !vecs[v].exp_i});
      chk($sformatf("v%0d_latency", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_we", v), cw, vecs[v].exp_we);
      chk($sformatf("v%0d_addr", v), ca, vecs[v].exp_addr);
      chk($sformatf("v%0d_wdata", v), cd, vecs[v].exp_wd);
      chk($sformatf("v%0d_mask", v), cm, vecs[v].exp_mask);
      chk($sformatf("v%0d_stable", v), st, 1);
      chk($sformatf("v%0d_ibus_data", v), rdi, vecs[v].exp_idata);
      chk($sformatf("v%0d_dbus_data", v), rdd, vecs[v].exp_ddata);
      ibus_req = 0; dbus_req = 0;
      tick();
      chk($sformatf("v%0d_pulse_len", v), {ibus_ready, dbus_ready}, 0);
    end

    // Reset while WAIT, followed by a late rvalid.
    dbus_req = 1; dbus_we = 0; dbus_addr = 32'h8000_0500; dbus_mask = 4'hF;
    tick();
    tick();
    chk("rw_issue", mem_req, 1);
    mem_gnt = 1;
    tick();
    mem_gnt = 0; dbus_req = 0; rst = 0;
    tick();
    rst = 1; mem_rvalid = 1; mem_rdata = 32'hBBBB_BBBB;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_ready", {ibus_ready, dbus_ready, mem_req}, 0);
      tick();
    end
    chk("rw_dbus_data", dbus_rdata, 0);
    ibus_req = 1; ibus_we = 0; ibus_addr = 32'h8000_0020; ibus_mask = 4'hF;
    run_mem(0, 0, 32'h0000_0042, gi, gd, cyc, cw, ca, cd, cm, rdi, rdd, st);
    chk("rw_after_winner", {gi, gd}, 2'b10);
    chk("rw_after_latency", cyc, 3);
    chk("rw_after_data", rdi, 32'h0000_0042);
    ibus_req = 0;
    tick();

    // Both requesters held: expect D,D,D,D,I,D,D,D,D,I.
    ibus_req = 1; dbus_req = 1; ibus_we = 0; dbus_we = 0;
    for (int k = 0; k < 10; k++) begin
      run_mem(0, 0, 32'h100 + k, gi, gd, cyc, cw, ca, cd, cm, rdi, rdd, st);
      chk($sformatf("starve%0d_winner", k), {gi, gd}, (k == 4 || k == 9) ? 2'b10 : 2'b01);
      chk($sformatf("starve%0d_data", k), gi ? rdi : rdd, 32'h100 + k);
      tick();
      chk($sformatf("starve%0d_pulse_len", k), {ibus_ready, dbus_ready}, 0);
    end
    ibus_req = 0; dbus_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
